// File: rtl/vga_term_ctrl_pkg.sv
// Shared console definitions: buffer geometry defaults, control codes and sequencer states.
package vga_term_ctrl_pkg;

    localparam int DEF_NUM_ROWS = 3;
    localparam int DEF_NUM_COLS = 10;

    localparam int ROW_W  = 2;
    localparam int COL_W  = 4;
    localparam int ADDR_W = 5;

    localparam logic [6:0] CC_LF    = 7'h0A;
    localparam logic [6:0] CC_CR    = 7'h0D;
    localparam logic [6:0] CC_BS    = 7'h08;
    localparam logic [6:0] CC_FF    = 7'h0C;
    localparam logic [6:0] CC_SPACE = 7'h20;
    localparam logic [7:0] BLANK    = {1'b0, CC_SPACE};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_CLR_ROW,
        ST_CLR_ALL
    } state_t;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code != 7'h7F);
    endfunction

    // row*ncols+col as a sum of shifted rows, one term per set bit of the constant ncols
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col,
                                                    input int ncols);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(col);
        for (int b = 0; b < ADDR_W; b++)
            if (ncols[b])
                acc = acc + (ADDR_W'(row) << b);
        return acc;
    endfunction

endpackage

// File: rtl/vga_term_ctrl_if.sv
// Byte stream into the terminal sequencer: valid/ready handshake with {color_sel, code} payload.
interface vga_term_ctrl_if;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;

    modport master (output ch_valid, output ch_data, input ch_ready);
    modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/vga_term_fifo.sv
// Synchronous byte FIFO; a push is refused whenever full, regardless of a same-cycle pop.
module vga_term_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push)
            mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/vga_term_ctrl.sv
// Terminal sequencer: sole writer of the text buffer; cursor, wrap, scroll and clear.
// IDLE:pop byte | EXEC:decode/write | SCR_RD/SCR_WR:copy up | CLR_ROW:blank last row | CLR_ALL:blank all
module vga_term_ctrl
    import vga_term_ctrl_pkg::*;
#(
    parameter int NUM_ROWS    = DEF_NUM_ROWS,
    parameter int NUM_COLS    = DEF_NUM_COLS,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_VBLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_term_ctrl_if.slave    ch,
    input  logic              vblank,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              buf_we,
    input  logic [7:0]        buf_rdata,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] NC_A      = ADDR_W'(NUM_COLS);
    localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(NUM_CHARS - NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(NUM_CHARS - NUM_COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CHARS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

    state_t            state;
    logic [6:0]        cur;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] idx, addr_q;
    logic [7:0]        wdata_q;
    logic              we_q;
    logic              go, pop, wants_lf;
    logic              fifo_empty, fifo_full;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    vga_term_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ch.ch_valid),
        .din   (ch.ch_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign go       = (SYNC_VBLANK != 0) ? vblank : 1'b1;
    assign pop      = (state == ST_IDLE) && !fifo_empty && go;
    assign wants_lf = (is_printable(cur) && (col == COL_LAST)) || (cur == CC_LF);

    assign ch.ch_ready = !fifo_full;
    assign buf_addr    = addr_q;
    assign buf_wdata   = wdata_q;
    assign buf_we      = we_q && go;    // a pending write simply waits out go=0
    assign cursor_row  = row;
    assign cursor_col  = col;
    assign busy        = (state != ST_IDLE) || (fifo_count != '0);

    // Whole FSM freezes while go=0, so address and phase are held across a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLR_ALL;
            cur     <= '0;
            row     <= '0;
            col     <= '0;
            idx     <= '0;
            addr_q  <= '0;
            wdata_q <= BLANK;
            we_q    <= 1'b0;
        end else if (go) begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur     <= fifo_dout[6:0];
                        addr_q  <= cell_addr(row, col, NUM_COLS);
                        wdata_q <= fifo_dout;
                        we_q    <= is_printable(fifo_dout[6:0]);
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    we_q  <= 1'b0;
                    if (is_printable(cur)) begin
                        col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
                    end else begin
                        case (cur)
                            CC_LF, CC_CR: col <= '0;
                            CC_BS: if (col != '0) col <= col - COL_W'(1);
                            CC_FF: begin
                                row     <= '0;
                                col     <= '0;
                                addr_q  <= '0;
                                wdata_q <= BLANK;
                                we_q    <= 1'b1;
                                state   <= ST_CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                    if (wants_lf) begin
                        if (row != ROW_LAST) begin
                            row <= row + ROW_W'(1);
                        end else begin
                            idx    <= '0;
                            addr_q <= NC_A;
                            state  <= ST_SCR_RD;
                        end
                    end
                end
                ST_SCR_RD: begin
                    wdata_q <= buf_rdata;
                    addr_q  <= idx;
                    we_q    <= 1'b1;
                    state   <= ST_SCR_WR;
                end
                ST_SCR_WR: begin
                    if (idx == SCR_LAST) begin
                        addr_q  <= LAST_BASE;
                        wdata_q <= BLANK;
                        state   <= ST_CLR_ROW;
                    end else begin
                        idx    <= idx + ADDR_W'(1);
                        addr_q <= idx + NC_A + ADDR_W'(1);
                        we_q   <= 1'b0;
                        state  <= ST_SCR_RD;
                    end
                end
                ST_CLR_ROW, ST_CLR_ALL: begin
                    // out of reset we_q is low, so the first cycle only arms the write
                    if (!we_q) begin
                        we_q <= 1'b1;
                    end else if (addr_q == LAST_CELL) begin
                        we_q  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: state <= ST_CLR_ALL;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl with a behavioural 30-cell text buffer and write log.
module tb_vga_term_ctrl;
    import vga_term_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vblank = 1'b1;
    logic [4:0] buf_addr;
    logic [7:0] buf_wdata, buf_rdata;
    logic       buf_we;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    logic [7:0] text [0:29];
    logic [4:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int n_vec = 0;
    int n_err = 0;

    vga_term_ctrl_if chif ();

    vga_term_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .FIFO_DEPTH(4), .SYNC_VBLANK(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch         (chif),
        .vblank     (vblank),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .buf_we     (buf_we),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign buf_rdata = (buf_addr < 5'd30) ? text[buf_addr] : 8'h00;

    always @(posedge clk) begin
        if (buf_we) begin
            text[buf_addr] <= buf_wdata;
            wr_addr_q.push_back(buf_addr);
            wr_data_q.push_back(buf_wdata);
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        chif.ch_valid = 1'b1;
        chif.ch_data  = b;
        while (!chif.ch_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_vec++; n_err++;
            $display("FAIL send_byte %h: ch_ready stayed 0 for %0d cycles, want 1", b, n);
        end
        @(posedge clk);
        #1 chif.ch_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, max_cyc);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        chif.ch_valid = 1'b0;
        chif.ch_data  = 8'h00;
        vblank = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (buf_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", buf_we); end
        n_vec++; if (buf_addr !== 5'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", buf_addr); end
        n_vec++; if (buf_wdata !== 8'h20) begin n_err++; $display("FAIL rst_wdata: got %h want 20", buf_wdata); end
        n_vec++; if ({cursor_row, cursor_col} !== 6'd0) begin n_err++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy); end
        rst_n = 1'b1;
        clear_log();
        @(negedge clk);
        n_vec++; if (chif.ch_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", chif.ch_ready); end
        wait_idle(200);
        n_vec++; if (wr_addr_q.size() != 30) begin n_err++; $display("FAIL init_clr_count: got %0d writes want 30", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 30; i++)
            if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'h20) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL init_clr_seq: %0d writes off, want addr 0..29 of 20", bad); end
    endtask

    task automatic test_text();
        send_byte(8'h41);
        send_byte(8'h42);
        wait_idle(50);
        n_vec++; if (text[0] !== 8'h41) begin n_err++; $display("FAIL text0: got %h want 41", text[0]); end
        n_vec++; if (text[1] !== 8'h42) begin n_err++; $display("FAIL text1: got %h want 42", text[1]); end
        n_vec++; if (cursor_row !== 2'd0 || cursor_col !== 4'd2) begin n_err++; $display("FAIL text_cursor: got (%0d,%0d) want (0,2)", cursor_row, cursor_col); end
    endtask

    task automatic test_wrap();
        int bad = 0;
        send_byte(8'h0C);
        wait_idle(100);
        for (int i = 0; i < 11; i++) send_byte(8'h58);
        wait_idle(100);
        for (int i = 0; i < 11; i++) if (text[i] !== 8'h58) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL wrap_cells: %0d of text[0..10] not 58", bad); end
        n_vec++; if (text[11] !== 8'h20) begin n_err++; $display("FAIL wrap_text11: got %h want 20", text[11]); end
        n_vec++; if (cursor_row !== 2'd1 || cursor_col !== 4'd1) begin n_err++; $display("FAIL wrap_cursor: got (%0d,%0d) want (1,1)", cursor_row, cursor_col); end
    endtask

    task automatic test_scroll();
        int bad = 0;
        int nb = 0;
        logic [7:0] exp [30];
        send_byte(8'h0C);
        wait_idle(100);
        for (int i = 0; i < 10; i++) send_byte(8'h61);
        for (int i = 0; i < 10; i++) send_byte(8'h62);
        for (int i = 0; i < 10; i++) send_byte(8'h63);
        wait_idle(400);
        for (int i = 0; i < 30; i++) exp[i] = (i < 10) ? 8'h62 : (i < 20) ? 8'h63 : 8'h20;
        for (int i = 0; i < 30; i++) if (text[i] !== exp[i]) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL wrap_scroll_rows: %0d cells off, want b/c/blank", bad); end
        n_vec++; if (cursor_row !== 2'd2 || cursor_col !== 4'd0) begin n_err++; $display("FAIL wrap_scroll_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
        clear_log();
        send_byte(8'h0A);
        @(negedge clk);
        while (busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        n_vec++; if (nb != 52) begin n_err++; $display("FAIL lf_scroll_cycles: busy for %0d cycles want 52", nb); end
        n_vec++; if (wr_addr_q.size() != 30) begin n_err++; $display("FAIL lf_scroll_writes: got %0d want 30", wr_addr_q.size()); end
        bad = 0;
        for (int i = 0; i < 30; i++) exp[i] = (i < 10) ? 8'h63 : 8'h20;
        for (int i = 0; i < 30; i++) if (text[i] !== exp[i]) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL lf_scroll_rows: %0d cells off, want c/blank/blank", bad); end
        n_vec++; if (cursor_row !== 2'd2 || cursor_col !== 4'd0) begin n_err++; $display("FAIL lf_scroll_cursor: got (%0d,%0d) want (2,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_vblank();
        int bad = 0;
        int n = 0;
        int n0;
        logic [7:0] exp [30];
        send_byte(8'h0C);
        wait_idle(100);
        vblank = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        n_vec++; if (chif.ch_ready !== 1'b0) begin n_err++; $display("FAIL vb_ready_full: got %b want 0", chif.ch_ready); end
        @(negedge clk);
        chif.ch_valid = 1'b1;
        chif.ch_data  = 8'h35;
        repeat (5) @(negedge clk);
        n_vec++; if (chif.ch_ready !== 1'b0) begin n_err++; $display("FAIL vb_ready_held: got %b want 0", chif.ch_ready); end
        n_vec++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL vb_no_write: got %0d writes want 0", wr_addr_q.size()); end
        vblank = 1'b1;
        while (!chif.ch_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 chif.ch_valid = 1'b0;
        wait_idle(100);
        n_vec++; if (wr_addr_q.size() != 5) begin n_err++; $display("FAIL vb_write_count: got %0d want 5", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 5; i++)
            if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 8'h31 + 8'(i)) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL vb_order: %0d writes off, want 31..35 at 0..4", bad); end

        send_byte(8'h0A);
        send_byte(8'h0A);
        send_byte(8'h5A);
        wait_idle(100);
        clear_log();
        send_byte(8'h0A);
        repeat (10) @(negedge clk);
        vblank = 1'b0;
        n0 = wr_addr_q.size();
        repeat (20) @(negedge clk);
        n_vec++; if (wr_addr_q.size() != n0) begin n_err++; $display("FAIL vb_stall: got %0d writes want %0d", wr_addr_q.size(), n0); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL vb_stall_busy: got %b want 1", busy); end
        vblank = 1'b1;
        wait_idle(200);
        n_vec++; if (wr_addr_q.size() != 30) begin n_err++; $display("FAIL vb_scroll_writes: got %0d want 30", wr_addr_q.size()); end
        bad = 0;
        for (int i = 0; i < 30; i++) exp[i] = (i == 10) ? 8'h5A : 8'h20;
        for (int i = 0; i < 30; i++) if (text[i] !== exp[i]) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL vb_scroll_rows: %0d cells off after stalled scroll", bad); end
    endtask

    task automatic test_controls();
        int bad = 0;
        send_byte(8'h0C);
        wait_idle(100);
        clear_log();
        send_byte(8'h08);
        wait_idle(50);
        n_vec++; if (cursor_col !== 4'd0 || wr_addr_q.size() != 0) begin n_err++; $display("FAIL bs_col0: col %0d writes %0d want 0 0", cursor_col, wr_addr_q.size()); end
        send_byte(8'hC1);
        wait_idle(50);
        n_vec++; if (text[0] !== 8'hC1) begin n_err++; $display("FAIL color_char: got %h want c1", text[0]); end
        send_byte(8'h07);
        wait_idle(50);
        n_vec++; if (wr_addr_q.size() != 1 || cursor_col !== 4'd1) begin n_err++; $display("FAIL ignore_07: writes %0d col %0d want 1 1", wr_addr_q.size(), cursor_col); end
        send_byte(8'h78);
        send_byte(8'h08);
        wait_idle(50);
        n_vec++; if (text[1] !== 8'h78 || cursor_col !== 4'd1) begin n_err++; $display("FAIL bs_dec: text1 %h col %0d want 78 1", text[1], cursor_col); end
        send_byte(8'h0D);
        wait_idle(50);
        n_vec++; if (cursor_col !== 4'd0 || cursor_row !== 2'd0) begin n_err++; $display("FAIL cr: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
        send_byte(8'h78);
        clear_log();
        send_byte(8'h0C);
        wait_idle(100);
        for (int i = 0; i < 30; i++) if (text[i] !== 8'h20) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL ff_cells: %0d cells not 20", bad); end
        n_vec++; if (wr_addr_q.size() != 31) begin n_err++; $display("FAIL ff_writes: got %0d want 31", wr_addr_q.size()); end
        n_vec++; if ({cursor_row, cursor_col} !== 6'd0) begin n_err++; $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_reset_mid_scroll();
        int n = 0;
        int bad = 0;
        send_byte(8'h0A);
        send_byte(8'h0A);
        send_byte(8'h51);
        wait_idle(100);
        send_byte(8'h0A);
        @(negedge clk);
        while (buf_we !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (buf_we !== 1'b1) begin n_err++; $display("FAIL mid_scroll_reach: buf_we %b want 1", buf_we); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (buf_we !== 1'b0 || buf_addr !== 5'd0 || buf_wdata !== 8'h20) begin n_err++; $display("FAIL mid_rst_outs: we %b addr %0d wdata %h want 0 0 20", buf_we, buf_addr, buf_wdata); end
        n_vec++; if ({cursor_row, cursor_col} !== 6'd0 || busy !== 1'b1) begin n_err++; $display("FAIL mid_rst_state: cursor (%0d,%0d) busy %b want (0,0) 1", cursor_row, cursor_col, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        wait_idle(200);
        for (int i = 0; i < 30; i++) if (text[i] !== 8'h20) bad++;
        n_vec++; if (wr_addr_q.size() != 30 || bad != 0) begin n_err++; $display("FAIL mid_rst_clear: writes %0d bad cells %0d want 30 0", wr_addr_q.size(), bad); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_text();
        test_wrap();
        test_scroll();
        test_vblank();
        test_controls();
        test_reset_mid_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
